// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and helpers for the PISO serializer.
// Holds the FSM state encoding and the bit-counter width function.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must index bits 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_rst_en.sv
// dff_rst_en: 1-bit flop, synchronous active-high reset, load enable.
// Ports: clk, reset, en, d -> q (reset value set by rst_val).
module dff_rst_en #(
    parameter logic rst_val = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= rst_val;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/serializer_piso.sv
// serializer_piso: nbits-wide word in (val/rdy), one bit per transfer out,
// LSB first with last marker. Ports: clk, reset, in_val/in_rdy/in_msg,
// out_val/out_rdy/out_msg/out_last.
module serializer_piso
    import serializer_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_msg,
    output logic             out_last
);

    localparam int CW = cnt_width(nbits);
    localparam logic [CW-1:0] LAST_IDX = CW'(nbits - 1);

    logic             state_bit;
    state_t           state_q;
    state_t           state_d;
    logic             state_en;
    logic [nbits-1:0] sreg_q;
    logic [nbits-1:0] sreg_d;
    logic             sreg_en;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             cnt_en;

    logic is_shift;
    logic at_last;
    logic in_fire;
    logic out_fire;
    logic load;
    logic shift;
    logic done;

    assign state_q  = state_t'(state_bit);
    assign is_shift = (state_q == SHIFT);
    assign at_last  = is_shift & (cnt_q == LAST_IDX);

    // Outputs are forced quiet during reset even though state
    // only clears at the next edge.
    assign out_val  = is_shift & ~reset;
    assign out_msg  = out_val & sreg_q[0];
    assign out_last = out_val & at_last;
    assign in_rdy   = ~reset & (~is_shift | (out_last & out_rdy));

    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    assign load  = in_fire;
    assign shift = out_fire & ~at_last;
    // Last bit leaves with nothing waiting behind it.
    assign done  = out_fire & at_last & ~in_val;

    always_comb begin
        sreg_d   = load ? in_msg : {1'b0, sreg_q[nbits-1:1]};
        sreg_en  = load | shift;
        cnt_d    = (load | done) ? '0 : cnt_q + 1'b1;
        cnt_en   = load | shift | done;
        state_d  = load ? SHIFT : IDLE;
        state_en = load | done;
    end

    dff_rst_en #(.rst_val(1'b0)) u_state (
        .clk   (clk),
        .reset (reset),
        .en    (state_en),
        .d     (logic'(state_d)),
        .q     (state_bit)
    );

    for (genvar i = 0; i < nbits; i++) begin : g_sreg
        dff_rst_en #(.rst_val(1'b0)) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (sreg_en),
            .d     (sreg_d[i]),
            .q     (sreg_q[i])
        );
    end

    for (genvar i = 0; i < CW; i++) begin : g_cnt
        dff_rst_en #(.rst_val(1'b0)) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (cnt_en),
            .d     (cnt_d[i]),
            .q     (cnt_q[i])
        );
    end

endmodule

// File: tb/tb_serializer_piso.sv
// tb_serializer_piso: directed bench for serializer_piso.
// Covers nbits=8 scenarios and the nbits=2 minimum-width case.
module tb_serializer_piso;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic       out_msg;
    logic       out_last;

    logic       reset2;
    logic       in_val2;
    logic       in_rdy2;
    logic [1:0] in_msg2;
    logic       out_val2;
    logic       out_rdy2;
    logic       out_msg2;
    logic       out_last2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serializer_piso #(.nbits(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last)
    );

    serializer_piso #(.nbits(2)) dut2 (
        .clk      (clk),
        .reset    (reset2),
        .in_val   (in_val2),
        .in_rdy   (in_rdy2),
        .in_msg   (in_msg2),
        .out_val  (out_val2),
        .out_rdy  (out_rdy2),
        .out_msg  (out_msg2),
        .out_last (out_last2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        in_val = 1'b1;
        in_msg = 8'hFF;
        out_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({in_rdy, out_val, out_msg, out_last} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got rdy/val/msg/last=%b want 0000",
                         c, {in_rdy, out_val, out_msg, out_last});
            end
            tick();
        end
        reset  = 1'b0;
        in_val = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release got rdy/val=%b want 10", {in_rdy, out_val});
        end
        tick();
    endtask

    task automatic test_single_word();
        logic exp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        in_val  = 1'b1;
        in_msg  = 8'hA5;
        out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_accept got rdy/val=%b want 10", {in_rdy, out_val});
        end
        tick();
        in_val = 1'b0;
        in_msg = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last} !== {1'b1, exp[i], i == 7}) begin
                n_fail++;
                $display("FAIL single_bit%0d got val/msg/last=%b want %b", i,
                         {out_val, out_msg, out_last}, {1'b1, exp[i], i == 7});
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_idle got rdy/val=%b want 10", {in_rdy, out_val});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp [16] = '{1, 1, 1, 1, 0, 0, 0, 0,
                           0, 0, 0, 0, 1, 1, 1, 1};
        in_val  = 1'b1;
        in_msg  = 8'h0F;
        out_rdy = 1'b1;
        tick();
        in_msg = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last, in_rdy} !==
                {1'b1, exp[i], i % 8 == 7, i % 8 == 7}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d got val/msg/last/rdy=%b want %b", i,
                         {out_val, out_msg, out_last, in_rdy},
                         {1'b1, exp[i], i % 8 == 7, i % 8 == 7});
            end
            tick();
            if (i == 7)
                in_val = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle got rdy/val=%b want 10", {in_rdy, out_val});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic exp [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        int b = 0;
        in_val  = 1'b1;
        in_msg  = 8'h81;
        out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        in_msg = 8'hFF;
        for (int c = 0; c < 40 && b < 8; c++) begin
            out_rdy = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last} !== {1'b1, exp[b], b == 7}) begin
                n_fail++;
                $display("FAIL bp_cyc%0d bit%0d got val/msg/last=%b want %b", c, b,
                         {out_val, out_msg, out_last}, {1'b1, exp[b], b == 7});
            end
            tick();
            if (out_rdy)
                b++;
        end
        n_checks++;
        if (b != 8) begin
            n_fail++;
            $display("FAIL bp_count got %0d bits want 8", b);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_rdy, out_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_idle got rdy/val=%b want 10", {in_rdy, out_val});
        end
        tick();
    endtask

    task automatic test_last_bit_stall();
        logic exp [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        in_val  = 1'b1;
        in_msg  = 8'h3C;
        out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        for (int i = 0; i < 7; i++)
            tick();
        in_val  = 1'b1;
        in_msg  = 8'h55;
        out_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last, in_rdy} !== 4'b1010) begin
                n_fail++;
                $display("FAIL stall_last cyc=%0d got val/msg/last/rdy=%b want 1010",
                         c, {out_val, out_msg, out_last, in_rdy});
            end
            tick();
        end
        out_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_last, in_rdy} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_release got last/rdy=%b want 11", {out_last, in_rdy});
        end
        tick();
        in_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last} !== {1'b1, exp[i], i == 7}) begin
                n_fail++;
                $display("FAIL stall_word2_bit%0d got val/msg/last=%b want %b", i,
                         {out_val, out_msg, out_last}, {1'b1, exp[i], i == 7});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_word();
        in_val  = 1'b1;
        in_msg  = 8'hFF;
        out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg} !== 2'b11) begin
                n_fail++;
                $display("FAIL rst_mid_bit%0d got val/msg=%b want 11", i,
                         {out_val, out_msg});
            end
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_val, in_rdy, out_msg} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_assert got val/rdy/msg=%b want 000",
                     {out_val, in_rdy, out_msg});
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_val, in_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_idle got val/rdy=%b want 01", {out_val, in_rdy});
        end
        in_val = 1'b1;
        in_msg = 8'h01;
        tick();
        in_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val, out_msg, out_last} !== {1'b1, i == 0, i == 7}) begin
                n_fail++;
                $display("FAIL rst_mid_word_bit%0d got val/msg/last=%b want %b", i,
                         {out_val, out_msg, out_last}, {1'b1, i == 0, i == 7});
            end
            tick();
        end
    endtask

    task automatic test_min_width();
        logic exp [4] = '{0, 1, 1, 0};
        reset2   = 1'b1;
        out_rdy2 = 1'b1;
        tick();
        reset2  = 1'b0;
        in_val2 = 1'b1;
        in_msg2 = 2'b10;
        tick();
        in_msg2 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_val2, out_msg2, out_last2, in_rdy2} !==
                {1'b1, exp[i], i % 2 == 1, i % 2 == 1}) begin
                n_fail++;
                $display("FAIL min_bit%0d got val/msg/last/rdy=%b want %b", i,
                         {out_val2, out_msg2, out_last2, in_rdy2},
                         {1'b1, exp[i], i % 2 == 1, i % 2 == 1});
            end
            tick();
            if (i == 1)
                in_val2 = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({in_rdy2, out_val2} !== 2'b10) begin
            n_fail++;
            $display("FAIL min_idle got rdy/val=%b want 10", {in_rdy2, out_val2});
        end
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        in_val   = 1'b0;
        in_msg   = 8'h00;
        out_rdy  = 1'b0;
        reset2   = 1'b1;
        in_val2  = 1'b0;
        in_msg2  = 2'b00;
        out_rdy2 = 1'b0;
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_last_bit_stall();
        test_reset_mid_word();
        test_min_width();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_piso.md
# serializer_piso

Parallel-in, serial-out serializer: accepts an `nbits`-wide word over a val/rdy handshake and emits it one bit per accepted output transfer, LSB first, with a last-bit marker. It is the transmit end of the team's serial link and pairs with the serial-in, parallel-out deserializer on the receive end. Storage is built from flip-flops with reset and enable, so the block sits one level above the basic DFF and latch primitives.

## Interface
- `nbits`, default 8: word width. Legal values are `nbits >= 2`.
- `clk` input 1: rising-edge clock. This is the block's only clock.
- `reset` input 1: synchronous, active-high reset.
- `in_val` input 1: parallel word valid.
- `in_rdy` output 1: serializer can accept a word this cycle.
- `in_msg` input `nbits`: parallel word.
- `out_val` output 1: serial bit valid.
- `out_rdy` input 1: downstream accepts the bit.
- `out_msg` output 1: current serial bit.
- `out_last` output 1: current bit is bit `nbits-1` of the word.

## Operation
- **State.**
  - FSM state: IDLE or SHIFT.
  - Shift register `sreg[nbits-1:0]`.
  - Bit counter `cnt`, width `$clog2(nbits)`.
- **Transfer definitions.**
  - Input fire = `in_val & in_rdy`.
  - Output fire = `out_val & out_rdy`.
- **IDLE.**
  - `in_rdy=1`, `out_val=0`.
  - On input fire: `sreg <= in_msg`, `cnt <= 0`, go to SHIFT.
- **SHIFT.**
  - `out_val=1`, `out_msg=sreg[0]`, `out_last = (cnt == nbits-1)`.
  - On output fire with `cnt != nbits-1`: `sreg <= sreg >> 1` (zero fill), `cnt <= cnt+1`, stay in SHIFT.
  - On output fire with `cnt == nbits-1`:
    - If `in_val` is also high, load the new word (`sreg <= in_msg`, `cnt <= 0`) and stay in SHIFT. This is the back-to-back case.
    - Otherwise go to IDLE and clear `cnt`.
- **`in_rdy` equation.** `in_rdy = !reset & ((state==IDLE) | (state==SHIFT & out_last & out_rdy))`. `in_rdy` is combinational from `out_rdy`; downstream must not make `out_rdy` depend on `in_rdy`.
- **Output gating.** `out_msg` and `out_last` are forced to 0 whenever `out_val=0`.
- **Stall.** While `out_rdy=0` in SHIFT, `sreg` and `cnt` hold. `out_msg` and `out_last` stay stable, and `out_val` stays high.
- **Ignored input.** `in_msg` is ignored whenever there is no input fire.

## Timing
- **Reset.**
  - Asserting `reset` at any edge, including mid-word, sets state to IDLE, `sreg=0` and `cnt=0`. The partial word is discarded.
  - While `reset` is high: `in_rdy=0`, `out_val=0`, `out_msg=0`, `out_last=0`.
  - First accept is possible in the first cycle after `reset` deasserts.
- **Latency.** Input fire at edge N gives `out_val=1` with bit 0 in cycle N+1.
- **Throughput.** One bit per cycle with `out_rdy` held high. Back-to-back words produce `nbits` consecutive bits with no bubble between words.
- **Word from IDLE.** A word accepted from IDLE occupies exactly `nbits` output fires, then returns to IDLE one cycle after the last fire if no new word is pending.
- **Simultaneous events.**
  - Last-bit output fire plus `in_val` in the same cycle: both transfers complete that cycle.
  - Last bit with `out_rdy=0`: `in_rdy=0`, and the pending `in_val` waits.

## Structure
- A shared package `serializer_pkg` holds:
  - the state enum typedef (IDLE=0, SHIFT=1);
  - a function or localparam computing the counter width from `nbits`.
- One sub-module, `dff_rst_en`: a 1-bit flop with synchronous reset, parameterizable reset value, and enable.
  - Instantiate one per state, `sreg` and `cnt` bit.
  - Next-state and enable logic, and the shift and increment muxing, are combinational in the top module.

## Test plan
- **Single word.** Reset, then one word with `out_rdy=1`.
  - Stimulus: `nbits=8`, `in_msg=8'hA5` accepted at cycle 1.
  - Required: `out_msg` over cycles 2–9 is 1,0,1,0,0,1,0,1, `out_last` high only in cycle 9, and `in_rdy=1` again in cycle 10.
- **Back-to-back.** `in_val` held high with `8'h0F` followed by `8'hF0` and `out_rdy=1`.
  - Required: 16 consecutive bits 1111 0000 0000 1111, no bubble, and `in_rdy` pulses in the cycle carrying the first word's last bit.
- **Backpressure.** `8'h81` with `out_rdy` toggling 1,0,0,1,…
  - Required: bits are never skipped or duplicated, outputs hold during stalls, and the bit sequence is 1,0,0,0,0,0,0,1.
- **Last-bit stall.** Drop `out_rdy` while `out_last=1` with `in_val` pending.
  - Required: `in_rdy=0` until `out_rdy` rises, then the new word is accepted in that same cycle.
- **Reset mid-word.** Assert `reset` after 3 bits of `8'hFF`.
  - Required: the next cycle shows `out_val=0`, `in_rdy=0`. After deassert, `8'h01` serializes correctly as 1 followed by seven 0s.
- **Minimum width.** `nbits=2`, words 2'b10 and 2'b01 sent back-to-back.
  - Required: bits 0,1,1,0, with `out_last` on the 2nd and 4th bits.
